// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - operation encodings carried on op_i
//   - FSM state type used by muldiv_unit
//   - small decode helpers for the operation field
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_MULT  = 2'b00;
    localparam logic [OP_W-1:0] OP_MULTU = 2'b01;
    localparam logic [OP_W-1:0] OP_DIV   = 2'b10;
    localparam logic [OP_W-1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Bit 1 of the encoding separates divide from multiply.
    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return op[1];
    endfunction

    // Bit 0 clear means the operands are two's-complement signed.
    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the magnitude datapath, shared between
// multiply and divide. Several copies are chained to retire more than one
// bit per clock.
//
// Ports:
//   div_i  : 1 = restoring-division step, 0 = shift-add multiply step
//   hi_i   : upper accumulator (partial product high / partial remainder)
//   lo_i   : lower accumulator (multiplier bits / dividend-quotient bits)
//   b_i    : multiplicand (multiply) or divisor magnitude (divide)
//   hi_o   : updated upper accumulator
//   lo_o   : updated lower accumulator
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;     // multiply: high half plus optional addend, with carry
    logic [XLEN:0] rem_sh;  // divide: remainder shifted left with next dividend bit
    logic [XLEN:0] diff;    // divide: trial subtraction, bit XLEN is the borrow

    always_comb begin
        sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : {(XLEN+1){1'b0}});
        rem_sh = {hi_i, lo_i[XLEN-1]};
        diff   = rem_sh - {1'b0, b_i};

        if (div_i) begin
            // The partial remainder stays below the divisor, so a clear
            // borrow means the trial result also fits in XLEN bits.
            if (diff[XLEN]) begin
                hi_o = rem_sh[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end else begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end
        end else begin
            // Shift {carry, hi, lo} right by one; the consumed multiplier
            // bit falls off the bottom of lo.
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative HI/LO multiply/divide unit. Operands are converted to magnitudes
// on accept, iterated for XLEN/BITS_PER_CYCLE cycles, sign-corrected in a
// single fix-up cycle, and the result is loaded into HI/LO on entry to DONE.
//
// Parameters:
//   XLEN           : operand width
//   BITS_PER_CYCLE : iteration bits per clock (1, 2 or 4; must divide XLEN)
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous reset, active low
//   start_i      : operation request (accepted in IDLE/DONE, flush_i low)
//   op_i         : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_i, rt_i   : multiplicand/dividend, multiplier/divisor
//   flush_i      : abort in-flight operation, back to IDLE next edge
//   mthi_i/mtlo_i: direct write of wdata_i into HI/LO (IDLE/DONE only)
//   wdata_i      : data for mthi/mtlo
//   hi_o, lo_o   : HI/LO registers
//   busy_o       : high during CALC and FIX
//   done_o       : one-cycle completion pulse
//   div_zero_o   : divisor was zero, valid with done_o
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            flush_i,
    input  logic            mthi_i,
    input  logic            mtlo_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            div_zero_o
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // FSM and datapath registers
    state_e          state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic            div_q,      div_d;
    logic            a_neg_q,    a_neg_d;   // first operand negative (signed ops only)
    logic            b_neg_q,    b_neg_d;   // second operand negative (signed ops only)
    logic            b_zero_q,   b_zero_d;
    logic [XLEN-1:0] opnd_q,     opnd_d;    // multiplicand or divisor magnitude
    logic [XLEN-1:0] acc_hi_q,   acc_hi_d;
    logic [XLEN-1:0] acc_lo_q,   acc_lo_d;
    logic [XLEN-1:0] hi_q,       hi_d;
    logic [XLEN-1:0] lo_q,       lo_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            div_zero_q, div_zero_d;

    // Combinational helpers
    logic              accept;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   rs_mag;
    logic [XLEN-1:0]   rt_mag;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_res;
    logic [XLEN-1:0]   quo_res;
    logic [XLEN-1:0]   rem_res;

    // Step chain: element 0 is the registered accumulator, the last element
    // is the state after BITS_PER_CYCLE iterations.
    logic [BITS_PER_CYCLE:0][XLEN-1:0] chain_hi;
    logic [BITS_PER_CYCLE:0][XLEN-1:0] chain_lo;

    assign chain_hi[0] = acc_hi_q;
    assign chain_lo[0] = acc_lo_q;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            muldiv_step #(
                .XLEN (XLEN)
            ) u_step (
                .div_i (div_q),
                .hi_i  (chain_hi[gi]),
                .lo_i  (chain_lo[gi]),
                .b_i   (opnd_q),
                .hi_o  (chain_hi[gi+1]),
                .lo_o  (chain_lo[gi+1])
            );
        end
    endgenerate

    always_comb begin
        accept = start_i && !flush_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        a_neg  = op_is_signed(op_i) && rs_i[XLEN-1];
        b_neg  = op_is_signed(op_i) && rt_i[XLEN-1];
        // The most-negative value maps to itself, which reads correctly as
        // an unsigned magnitude.
        rs_mag = a_neg ? -rs_i : rs_i;
        rt_mag = b_neg ? -rt_i : rt_i;

        prod_mag = {acc_hi_q, acc_lo_q};
        prod_res = (a_neg_q ^ b_neg_q) ? -prod_mag : prod_mag;
        // Divide by zero: the magnitude remainder equals |rs| and negating
        // it restores rs, but the quotient sign fix would spoil all-ones.
        quo_res  = b_zero_q ? {XLEN{1'b1}}
                            : ((a_neg_q ^ b_neg_q) ? -acc_lo_q : acc_lo_q);
        rem_res  = a_neg_q ? -acc_hi_q : acc_hi_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        b_zero_d   = b_zero_q;
        opnd_d     = opnd_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (mthi_i) begin
                    hi_d = wdata_i;
                end
                if (mtlo_i) begin
                    lo_d = wdata_i;
                end
                if (accept) begin
                    state_d  = ST_CALC;
                    cnt_d    = '0;
                    div_d    = op_is_div(op_i);
                    a_neg_d  = a_neg;
                    b_neg_d  = b_neg;
                    b_zero_d = (rt_i == '0);
                    acc_hi_d = '0;
                    // Multiply iterates over the multiplier in lo; divide
                    // shifts the dividend out of lo into the remainder.
                    if (op_is_div(op_i)) begin
                        opnd_d   = rt_mag;
                        acc_lo_d = rs_mag;
                    end else begin
                        opnd_d   = rs_mag;
                        acc_lo_d = rt_mag;
                    end
                end
            end

            ST_CALC: begin
                acc_hi_d = chain_hi[BITS_PER_CYCLE];
                acc_lo_d = chain_lo[BITS_PER_CYCLE];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                state_d    = ST_DONE;
                done_d     = 1'b1;
                div_zero_d = div_q && b_zero_q;
                if (div_q) begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end else begin
                    hi_d = prod_res[2*XLEN-1:XLEN];
                    lo_d = prod_res[XLEN-1:0];
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides everything except reset, including a result load.
        if (flush_i) begin
            state_d    = ST_IDLE;
            done_d     = 1'b0;
            div_zero_d = 1'b0;
            if (state_q == ST_FIX) begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        end

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            b_zero_q   <= 1'b0;
            opnd_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            b_zero_q   <= b_zero_d;
            opnd_q     <= opnd_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (XLEN=32, BITS_PER_CYCLE=1).
// Expected HI/LO/div_zero are computed from plain SV arithmetic when an
// operation is started, queued, and compared when done_o is seen.
// Edge counting treats the accepting edge as edge 1, so done_o is expected
// on edge N+2 and busy_o on N+1 sampled cycles.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int BPC  = 1;
    localparam int N    = XLEN / BPC;

    logic            clk;
    logic            rst_i;
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs_i;
    logic [XLEN-1:0] rt_i;
    logic            flush_i;
    logic            mthi_i;
    logic            mtlo_i;
    logic [XLEN-1:0] wdata_i;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;
    logic            busy_o;
    logic            done_o;
    logic            div_zero_o;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        exp_q[$];
    int          tests_run;
    int          fails;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    muldiv_unit #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .flush_i    (flush_i),
        .mthi_i     (mthi_i),
        .mtlo_i     (mtlo_i),
        .wdata_i    (wdata_i),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic, independent of the iterative algorithm.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic        [63:0] up;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        e.dz = 1'b0;
        case (op)
            OP_MULT: begin
                sp = sa * sb;
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            OP_DIV: begin
                if (b == 32'b0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    e.hi = sr[31:0];
                    e.lo = sq[31:0];
                end
            end
            default: begin
                if (b == 32'b0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
                end else begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Caller is just after a falling edge; start is sampled on the next rise.
    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit push);
        start_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        if (push) exp_q.push_back(model(op, a, b));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for done_o after a drive_start; optionally pulses start_i and
    // mthi_i while busy (both must be ignored by the DUT).
    task automatic wait_result(input string tag, input int pulse_at, input int mthi_at);
        int   k;
        int   busy_cnt;
        bit   seen;
        exp_t e;
        k = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            start_i = 1'b0;
            mthi_i  = 1'b0;
            if (k == pulse_at) begin
                start_i = 1'b1; op_i = OP_DIVU; rs_i = 32'hFFFF_FFFF; rt_i = 32'h1;
            end
            if (k == mthi_at) begin
                mthi_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
            end
            if (busy_o) busy_cnt++;
            if (done_o) begin
                seen = 1'b1;
                tests_run++;
                if (k != N + 2) begin
                    fails++;
                    $display("FAIL %s latency: got %0d edges, want %0d", tag, k, N + 2);
                end
                tests_run++;
                if (busy_cnt != N + 1) begin
                    fails++;
                    $display("FAIL %s busy_cycles: got %0d, want %0d", tag, busy_cnt, N + 1);
                end
                if (exp_q.size() == 0) begin
                    tests_run++; fails++;
                    $display("FAIL %s scoreboard: done_o with no expected result queued", tag);
                end else begin
                    e = exp_q.pop_front();
                    last_hi = e.hi;
                    last_lo = e.lo;
                    tests_run++;
                    if (hi_o !== e.hi) begin
                        fails++;
                        $display("FAIL %s hi: got %08h, want %08h", tag, hi_o, e.hi);
                    end
                    tests_run++;
                    if (lo_o !== e.lo) begin
                        fails++;
                        $display("FAIL %s lo: got %08h, want %08h", tag, lo_o, e.lo);
                    end
                    tests_run++;
                    if (div_zero_o !== e.dz) begin
                        fails++;
                        $display("FAIL %s div_zero: got %0b, want %0b", tag, div_zero_o, e.dz);
                    end
                end
                $display("[TB] %s: hi=%08h lo=%08h dz=%0b edges=%0d", tag, hi_o, lo_o, div_zero_o, k);
            end
        end
        if (!seen) begin
            tests_run++; fails++;
            $display("FAIL %s timeout: no done_o within 200 cycles", tag);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++; if (hi_o !== 32'b0) begin fails++; $display("FAIL reset_hi: got %08h, want 0", hi_o); end
        tests_run++; if (lo_o !== 32'b0) begin fails++; $display("FAIL reset_lo: got %08h, want 0", lo_o); end
        tests_run++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b, want 0", busy_o); end
        tests_run++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b, want 0", done_o); end
        tests_run++; if (div_zero_o !== 1'b0) begin fails++; $display("FAIL reset_dz: got %0b, want 0", div_zero_o); end
        $display("[TB] reset: hi=%08h lo=%08h busy=%0b", hi_o, lo_o, busy_o);
        rst_i = 1'b1;
        idle(1);
    endtask

    task automatic test_move();
        mthi_i = 1'b1; wdata_i = 32'h1234_5678;
        @(negedge clk);
        mthi_i = 1'b0; mtlo_i = 1'b1; wdata_i = 32'h9ABC_DEF0;
        @(negedge clk);
        mtlo_i = 1'b0;
        tests_run++; if (hi_o !== 32'h1234_5678) begin fails++; $display("FAIL mthi: got %08h, want 12345678", hi_o); end
        tests_run++; if (lo_o !== 32'h9ABC_DEF0) begin fails++; $display("FAIL mtlo: got %08h, want 9abcdef0", lo_o); end
        $display("[TB] move: hi=%08h lo=%08h", hi_o, lo_o);
    endtask

    task automatic test_multu();
        idle(1);
        drive_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_result("multu_max", 0, 0);
        tests_run++;
        if ({hi_o, lo_o} !== 64'hFFFF_FFFE_0000_0001) begin
            fails++; $display("FAIL multu_const: got %08h_%08h, want fffffffe_00000001", hi_o, lo_o);
        end
        @(negedge clk);
        tests_run++;
        if (done_o !== 1'b0) begin fails++; $display("FAIL done_pulse_width: done_o still %0b one cycle later", done_o); end
    endtask

    task automatic test_mult_div();
        idle(2);
        drive_start(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);          // -3 * 7
        wait_result("mult_neg", 0, 0);
        idle(1);
        drive_start(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);           // -7 / 2
        wait_result("div_neg", 0, 0);
        idle(1);
        drive_start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   // MIN / -1
        wait_result("div_ovf", 0, 0);
        idle(1);
        drive_start(OP_DIVU, 32'd5, 32'd0, 1'b1);
        wait_result("divu_zero", 0, 0);
        idle(1);
        drive_start(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b1);
        wait_result("div_zero_neg", 0, 0);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 3) ? 32'($urandom_range(1, 15)) : $urandom;
            idle(1);
            drive_start(op, a, b, 1'b1);
            wait_result($sformatf("rand%0d_op%0d", i, op), 0, 0);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        idle(1);
        prev_hi = last_hi;
        prev_lo = last_lo;
        drive_start(OP_MULTU, 32'h0001_2345, 32'h0006_789A, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (k == 10) flush_i = 1'b1;
        end
        flush_i = 1'b0;
        tests_run++; if (busy_o !== 1'b0) begin fails++; $display("FAIL flush_busy: got %0b, want 0", busy_o); end
        tests_run++; if (done_o !== 1'b0) begin fails++; $display("FAIL flush_done: got %0b, want 0", done_o); end
        tests_run++; if (hi_o !== prev_hi) begin fails++; $display("FAIL flush_hi: got %08h, want %08h", hi_o, prev_hi); end
        tests_run++; if (lo_o !== prev_lo) begin fails++; $display("FAIL flush_lo: got %08h, want %08h", lo_o, prev_lo); end
        $display("[TB] flush: busy=%0b hi=%08h lo=%08h", busy_o, hi_o, lo_o);
        @(negedge clk);
        drive_start(OP_MULT, 32'hFFFF_FFFB, 32'd9, 1'b1);
        wait_result("flush_restart", 0, 0);
    endtask

    task automatic test_back_to_back();
        idle(2);
        drive_start(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);
        wait_result("b2b_first", 5, 8);
        drive_start(OP_MULTU, 32'h0BAD_F00D, 32'h0000_1001, 1'b1);
        wait_result("b2b_second", 0, 0);
    endtask

    task automatic test_reset_mid();
        int seen;
        idle(2);
        drive_start(OP_DIVU, 32'd1000, 32'd3, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        tests_run++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %0b, want 0", busy_o); end
        tests_run++; if ({hi_o, lo_o} !== 64'b0) begin fails++; $display("FAIL rstmid_hilo: got %08h_%08h, want 0", hi_o, lo_o); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        tests_run++; if (seen != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d pulses, want 0", seen); end
        $display("[TB] reset_mid: busy=%0b done_pulses=%0d", busy_o, seen);
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        last_hi   = 32'b0;
        last_lo   = 32'b0;
        rst_i     = 1'b0;
        start_i   = 1'b0;
        op_i      = 2'b00;
        rs_i      = 32'b0;
        rt_i      = 32'b0;
        flush_i   = 1'b0;
        mthi_i    = 1'b0;
        mtlo_i    = 1'b0;
        wdata_i   = 32'b0;

        test_reset();
        test_move();
        test_multu();
        test_mult_div();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();

        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results never produced, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
